// File: rtl/exp_result_fifo.sv
// First-word-fall-through result FIFO placed after the Taylor-series exp(x) evaluator.
// Optional Q2.14 saturating head view is enabled by defining EXP_FIFO_Q214_SAT_EN.
module exp_result_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [AW:0]      o_count
`ifdef EXP_FIFO_Q214_SAT_EN
   ,
   output logic [15:0]      o_y_q214
`endif
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_s, pop_s;
   logic             ready_s, valid_s;

   // Handshake flags; ready depends only on held state and reset, never on i_valid/i_ready.
   always_comb begin
      ready_s = reset & (count_q != FULL_CNT);
      valid_s = (count_q != {(AW+1){1'b0}});
      push_s  = i_valid & ready_s;
      pop_s   = valid_s & i_ready;
   end

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset discards held entries at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not cleared; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // Head presentation: zeros whenever nothing is held.
   always_comb begin
      o_ready = ready_s;
      o_valid = valid_s;
      o_count = count_q;
      if (valid_s) begin
         o_data = mem_q[rd_ptr_q];
      end else begin
         o_data = {WIDTH{1'b0}};
      end
   end

`ifdef EXP_FIFO_Q214_SAT_EN
   // Q7.25 -> Q2.14: any integer bit above bit 1 overflows the range, so saturate.
   function automatic logic [15:0] q725_to_q214(input logic [WIDTH-1:0] y);
      if (y[31:27] != 5'd0) begin
         q725_to_q214 = 16'hFFFF;
      end else begin
         q725_to_q214 = y[26:11];
      end
   endfunction

   // Empty head is already forced to zero, which converts to zero.
   always_comb begin
      o_y_q214 = q725_to_q214(o_data);
   end
`endif

endmodule

// File: tb/tb_exp_result_fifo.sv
// Self-checking bench for exp_result_fifo: directed fill/drain/wrap/reset steps plus a
// randomized phase, all checked against a queue-based reference model.
module tb_exp_result_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic [2:0]  o_count;
`ifdef EXP_FIFO_Q214_SAT_EN
   logic [15:0] o_y_q214;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] model_q[$];
   logic [31:0] popped_q[$];

   exp_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_count (o_count)
`ifdef EXP_FIFO_Q214_SAT_EN
      ,
      .o_y_q214(o_y_q214)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's view of the queue.
   task automatic check_all(input string tag);
      logic [31:0] head;
      head = (model_q.size() != 0) ? model_q[0] : 32'h0;
      chk({tag, ".count"}, 32'(o_count), 32'(model_q.size()));
      chk({tag, ".valid"}, 32'(o_valid), 32'(model_q.size() != 0));
      chk({tag, ".ready"}, 32'(o_ready), 32'(reset && model_q.size() != DEPTH));
      chk({tag, ".data"},  o_data, head);
`ifdef EXP_FIFO_Q214_SAT_EN
      chk({tag, ".q214"}, 32'(o_y_q214),
          (model_q.size() == 0) ? 32'h0 :
          (head[31:27] != 5'd0) ? 32'hFFFF : 32'(head[26:11]));
`endif
   endtask

   // One clock: drive, predict push/pop from the pre-edge model, advance, check.
   task automatic step(input logic v, input logic [31:0] d, input logic r, input string tag);
      bit push, pop;
      i_valid = v;
      i_data  = d;
      i_ready = r;
      push = v && (model_q.size() != DEPTH);
      pop  = r && (model_q.size() != 0);
      @(posedge clk);
      #1;
      if (pop) popped_q.push_back(model_q.pop_front());
      if (push) model_q.push_back(d);
      check_all(tag);
   endtask

   initial begin
      int cyc;
      int next_word;
      logic [31:0] rd;
      reset   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset.ready_low", 32'(o_ready), 32'h0);
      reset = 1'b1;
      #1;
      chk("release.ready", 32'(o_ready), 32'h1);

      // Fill with the consumer stalled, then try a fifth word.
      step(1'b1, 32'h0200_0000, 1'b0, "fill1");
      chk("fill1.cnt", 32'(o_count), 32'd1);
      step(1'b1, 32'h0300_0000, 1'b0, "fill2");
      step(1'b1, 32'h0400_0000, 1'b0, "fill3");
      step(1'b1, 32'h0500_0000, 1'b0, "fill4");
      chk("fill4.cnt", 32'(o_count), 32'd4);
      chk("fill4.ready", 32'(o_ready), 32'h0);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, "drop5");
      chk("drop5.cnt", 32'(o_count), 32'd4);
      chk("drop5.head", o_data, 32'h0200_0000);

      // Drain, checking literal order on each cycle.
      chk("drain0", o_data, 32'h0200_0000);
      step(1'b0, 32'h0, 1'b1, "drain1");
      chk("drain1.lit", o_data, 32'h0300_0000);
      step(1'b0, 32'h0, 1'b1, "drain2");
      chk("drain2.lit", o_data, 32'h0400_0000);
      step(1'b0, 32'h0, 1'b1, "drain3");
      chk("drain3.lit", o_data, 32'h0500_0000);
      step(1'b0, 32'h0, 1'b1, "drain4");
      chk("empty.valid", 32'(o_valid), 32'h0);
      chk("empty.data", o_data, 32'h0);
      chk("empty.cnt", 32'(o_count), 32'h0);
      step(1'b0, 32'h0, 1'b1, "empty_pop");

      // Push into empty: no bypass in the push cycle.
      i_valid = 1'b1; i_data = 32'h0800_0000; i_ready = 1'b1;
      #1;
      chk("nobypass.valid", 32'(o_valid), 32'h0);
      step(1'b1, 32'h0800_0000, 1'b1, "prime1");
      step(1'b1, 32'h0000_1234, 1'b0, "prime2");
      popped_q.delete();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'h100 + 32'(i), 1'b1, "conc");
         chk("conc.cnt2", 32'(o_count), 32'd2);
      end
      chk("conc.first_out", popped_q[0], 32'h0800_0000);
      chk("conc.last_out", popped_q[7], 32'h105);
      while (model_q.size() != 0) step(1'b0, 32'h0, 1'b1, "flush");

      // Wrap: ten words with the consumer toggling.
      popped_q.delete();
      next_word = 1;
      cyc = 0;
      while ((popped_q.size() < 10) && (cyc < 100)) begin
         if ((next_word <= 10) && (model_q.size() != DEPTH)) begin
            step(1'b1, 32'(next_word), cyc[0], "wrap");
            next_word++;
         end else begin
            step(1'b0, 32'h0, cyc[0], "wrap");
         end
         cyc++;
      end
      chk("wrap.n", 32'(popped_q.size()), 32'd10);
      for (int i = 0; i < popped_q.size(); i++) chk("wrap.order", popped_q[i], 32'(i + 1));

      // Mid-operation reset with three entries held.
      step(1'b1, 32'h0AAA_0001, 1'b0, "pre_rst");
      step(1'b1, 32'h0AAA_0002, 1'b0, "pre_rst");
      step(1'b1, 32'h0AAA_0003, 1'b0, "pre_rst");
      chk("pre_rst.cnt", 32'(o_count), 32'd3);
      i_valid = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      model_q.delete();
      check_all("midrst");
      chk("midrst.ready", 32'(o_ready), 32'h0);
      #2;
      reset = 1'b1;
      #1;
      check_all("post_rst");
      step(1'b1, 32'h0BBB_0001, 1'b0, "post_push");
      chk("post_push.cnt", 32'(o_count), 32'd1);
      chk("post_push.data", o_data, 32'h0BBB_0001);
      step(1'b0, 32'h0, 1'b1, "post_pop");

`ifdef EXP_FIFO_Q214_SAT_EN
      step(1'b1, 32'h0200_0000, 1'b0, "q214a");
      chk("q214.one", 32'(o_y_q214), 32'h4000);
      step(1'b0, 32'h0, 1'b1, "q214b");
      step(1'b1, 32'h0800_0000, 1'b0, "q214c");
      chk("q214.sat", 32'(o_y_q214), 32'hFFFF);
      step(1'b0, 32'h0, 1'b1, "q214d");
      chk("q214.empty", 32'(o_y_q214), 32'h0);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         rd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 32'h0FFF_FFFF)) : $urandom;
         step(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
